// File: rtl/pll_ctrl_if.sv
// pll_ctrl_if: PLL lock/control lines, dynamic settings and reconfiguration handshake
interface pll_ctrl_if;
  logic       pll_lock, pll_pwd, pll_rst, ready, fault;
  logic       cfg_req, cfg_ack, cfg_err;
  logic [9:0] cfg_odiv0, cfg_odiv1, cfg_duty0, cfg_duty1;
  logic [9:0] dyn_odiv0, dyn_odiv1, dyn_duty0, dyn_duty1;
  logic [7:0] lock_loss_cnt;
  modport master (
    output pll_lock, cfg_req, cfg_odiv0, cfg_odiv1, cfg_duty0, cfg_duty1,
    input  pll_pwd, pll_rst, ready, fault, cfg_ack, cfg_err,
           dyn_odiv0, dyn_odiv1, dyn_duty0, dyn_duty1, lock_loss_cnt
  );
  modport slave (
    input  pll_lock, cfg_req, cfg_odiv0, cfg_odiv1, cfg_duty0, cfg_duty1,
    output pll_pwd, pll_rst, ready, fault, cfg_ack, cfg_err,
           dyn_odiv0, dyn_odiv1, dyn_duty0, dyn_duty1, lock_loss_cnt
  );
endinterface

// File: rtl/pll_ctrl.sv
// pll_ctrl: PLL bring-up sequencer with lock debounce, timeout retry, lock-loss recovery and runtime reconfiguration
module pll_ctrl #(
  parameter int         PWD_CYCLES   = 10,
  parameter int         RST_CYCLES   = 10,
  parameter int         LOCK_STABLE  = 16,
  parameter int         LOCK_TIMEOUT = 65535,
  parameter int         MAX_RETRY    = 3,
  parameter logic [9:0] ODIV_DEF     = 10'd100,
  parameter logic [9:0] DUTY_DEF     = 10'd100
) (
  input logic       clk,
  input logic       rst,
  pll_ctrl_if.slave bus
);
  localparam logic [15:0] PWD_LAST = 16'(PWD_CYCLES - 1);
  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [15:0] STAB_N   = 16'(LOCK_STABLE);
  localparam logic [15:0] TMO      = 16'(LOCK_TIMEOUT);
  localparam logic [7:0]  RETRY_N  = 8'(MAX_RETRY);
  typedef enum logic [2:0] {PWD, RST, WAIT_LOCK, LOCKED, RECFG, FAULT} state_t;
  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic [15:0]     cnt_q, cnt_d, stab_q, stab_d;
  logic [7:0]      retry_q, retry_d, loss_q, loss_d;
  logic [3:0][9:0] dyn_q, dyn_d;
  logic            blk_q, blk_d, ack_q, ack_d, err_q, err_d;
  logic            pwd_q, pwd_d, prst_q, prst_d, ready_q, ready_d, fault_q, fault_d;
  logic            lock_s, cfg_bad;
  assign lock_s  = sync_q[1];
  assign cfg_bad = bus.cfg_odiv0 == '0 || bus.cfg_odiv1 == '0 ||
                   bus.cfg_duty0 == '0 || bus.cfg_duty1 == '0;
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    dyn_d   = dyn_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      PWD:       state_d = cnt_q == PWD_LAST ? RST : PWD;
      RST:       state_d = cnt_q == RST_LAST ? WAIT_LOCK : RST;
      WAIT_LOCK: begin
        if (stab_q == STAB_N) begin
          state_d = LOCKED;
          retry_d = '0;
        end else if (cnt_q == TMO) begin
          retry_d = retry_q + 8'd1;
          state_d = retry_d < RETRY_N ? PWD : FAULT;
        end
      end
      LOCKED: begin
        if (!lock_s) begin
          state_d = RST;
          loss_d  = loss_q == 8'hff ? loss_q : loss_q + 8'd1;
        end else if (bus.cfg_req && !blk_q) begin
          state_d = RECFG;
        end
      end
      RECFG: begin
        ack_d   = 1'b1;
        err_d   = cfg_bad;
        state_d = cfg_bad ? LOCKED : RST;
        dyn_d   = cfg_bad ? dyn_q : {bus.cfg_duty1, bus.cfg_duty0, bus.cfg_odiv1, bus.cfg_odiv0};
      end
      default:   state_d = FAULT;
    endcase
    cnt_d   = state_d == state_q ? cnt_q + 16'd1 : '0;
    stab_d  = state_q == WAIT_LOCK && lock_s ? stab_q + 16'd1 : '0;
    blk_d   = ack_d | (blk_q & bus.cfg_req);
    pwd_d   = state_d == PWD;
    prst_d  = state_d inside {PWD, RST, FAULT};
    ready_d = state_d inside {LOCKED, RECFG};
    fault_d = state_d == FAULT;
  end
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[0], bus.pll_lock};
    if (rst) begin
      state_q <= PWD;
      cnt_q   <= '0;
      stab_q  <= '0;
      retry_q <= '0;
      loss_q  <= '0;
      dyn_q   <= {DUTY_DEF, DUTY_DEF, ODIV_DEF, ODIV_DEF};
      blk_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      pwd_q   <= 1'b1;
      prst_q  <= 1'b1;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stab_q  <= stab_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
      dyn_q   <= dyn_d;
      blk_q   <= blk_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      pwd_q   <= pwd_d;
      prst_q  <= prst_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end
  assign bus.pll_pwd       = pwd_q;
  assign bus.pll_rst       = prst_q;
  assign bus.ready         = ready_q;
  assign bus.fault         = fault_q;
  assign bus.cfg_ack       = ack_q;
  assign bus.cfg_err       = err_q;
  assign bus.lock_loss_cnt = loss_q;
  assign bus.dyn_odiv0     = dyn_q[0];
  assign bus.dyn_odiv1     = dyn_q[1];
  assign bus.dyn_duty0     = dyn_q[2];
  assign bus.dyn_duty1     = dyn_q[3];
endmodule

// File: doc/pll_ctrl.md
# pll_ctrl

Sequencer and reconfiguration controller for the `pll` core. It performs the power-down → reset → lock-acquire bring-up sequence, debounces `pll_lock`, and retries on lock timeout. It recovers automatically from lock loss and applies runtime output-divider/duty updates through a req/ack handshake, re-locking after each update. It sits in the `clk` domain (free-running reference clock, not a PLL output) between system control logic and the `pll` instance.

## Interface
Parameters:
- PWD_CYCLES, 10: cycles `pll_pwd` is held high per bring-up.
- RST_CYCLES, 10: cycles `pll_rst` is held high per reset pulse.
- LOCK_STABLE, 16: consecutive synchronized-lock cycles required to declare lock.
- LOCK_TIMEOUT, 65535: cycles allowed in WAIT_LOCK before a retry; timer is 16 bits.
- MAX_RETRY, 3: lock-timeout retries before FAULT.
- ODIV_DEF, 100: reset value of `dyn_odiv0`/`dyn_odiv1`.
- DUTY_DEF, 100: reset value of `dyn_duty0`/`dyn_duty1`.

Ports:
- clk  in  1  controller clock.
- rst  in  1  synchronous, active-high reset.
- pll_lock  in  1  raw lock from PLL; asynchronous, double-flop synchronized internally to `lock_s`.
- cfg_req  in  1  reconfiguration request; level, held with data until `cfg_ack`.
- cfg_odiv0, cfg_odiv1  in  10  requested output dividers.
- cfg_duty0, cfg_duty1  in  10  requested duty settings.
- cfg_ack  out  1  one-cycle acknowledge of `cfg_req`.
- cfg_err  out  1  one-cycle pulse, coincident with `cfg_ack`, when the request was rejected.
- pll_pwd  out  1  PLL power-down.
- pll_rst  out  1  PLL reset.
- dyn_odiv0, dyn_odiv1, dyn_duty0, dyn_duty1  out  10  registered dynamic settings to the PLL.
- ready  out  1  PLL locked and stable.
- fault  out  1  retries exhausted; sticky until `rst`.
- lock_loss_cnt  out  8  count of lock losses from LOCKED; saturates at 255.

## Operation
- All outputs are registered. Values while `rst` is high: state=PWD, `pll_pwd`=1, `pll_rst`=1, dyn_* = defaults, `ready`=0, `fault`=0, `cfg_ack`=0, `cfg_err`=0, `lock_loss_cnt`=0, retry=0, timers=0.
- **PWD**: `pll_pwd`=1, `pll_rst`=1 for PWD_CYCLES. Then go to RST and drive `pll_pwd`=0.
- **RST**: `pll_rst`=1 for RST_CYCLES. Then go to WAIT_LOCK and drive `pll_rst`=0; timeout and stable counters clear.
- **WAIT_LOCK**:
  - Stable counter increments while `lock_s`=1 and clears when `lock_s`=0.
  - When it reaches LOCK_STABLE: go to LOCKED, `ready`=1, retry=0.
  - If the timeout timer reaches LOCK_TIMEOUT first: retry+1. If retry < MAX_RETRY, go to PWD (full power cycle); otherwise go to FAULT.
- **LOCKED**: `ready`=1.
  - `lock_s`=0: `ready`=0, `lock_loss_cnt`+1 (saturating), go to RST. Retry count is not incremented.
  - Else, `cfg_req`=1: go to RECFG.
  - Lock loss takes priority over `cfg_req` in the same cycle. The request stays pending and is served after re-lock.
- **RECFG** (1 cycle):
  - Pulse `cfg_ack`.
  - If any `cfg_odiv*`==0 or any `cfg_duty*`==0: pulse `cfg_err`, leave dyn_* unchanged, return to LOCKED with `ready` still 1.
  - Otherwise: latch all four cfg_* into dyn_*, set `ready`=0, go to RST.
- **FAULT**: `pll_rst`=1, `pll_pwd`=0, `fault`=1, `ready`=0. The only exit is `rst`.
- `cfg_req` is not acknowledged outside LOCKED. After `cfg_ack` the requester must deassert `cfg_req` for at least one cycle before a new request; a still-high `cfg_req` in the cycle after ack is not re-served.
- dyn_* change only in RECFG (or on reset), so they never change while `pll_rst`=0.

## Timing
- Bring-up from `rst` falling, lock already stable: `pll_pwd` falls after PWD_CYCLES. `pll_rst` falls after a further RST_CYCLES. `ready` rises 2 (sync) + LOCK_STABLE cycles after `pll_lock` is first seen high in WAIT_LOCK, then +1 register.
- `pll_lock` falling edge → `ready`=0 within 3 cycles (2 sync + 1).
- `cfg_req` rising in LOCKED → `cfg_ack` 2 cycles later (LOCKED sample, RECFG). dyn_* update and `pll_rst`=1 on the same edge as `cfg_ack`.
- `rst` asserted mid-operation: all outputs are at reset values on the next edge, including `pll_pwd`=1.

## Test plan
- Defaults, `pll_lock` modeled high 100 cycles after `pll_rst` falls → `pll_pwd` low at cycle 10, `pll_rst` low at 20, `ready`=1 at about 139; dyn_* stay 100.
- Valid reconfig: in LOCKED, `cfg_req`=1 with odiv0/1=200 and duty0/1=200 → `cfg_ack` pulse. dyn_*=200 and `pll_rst`=1 on the same edge, `pll_rst` high for 10 cycles, `ready` re-asserts after relock.
- Reject: `cfg_odiv1`=0 → `cfg_ack` and `cfg_err` pulse together. dyn_* unchanged, `ready` stays 1, no `pll_rst` pulse.
- Lock timeout: `pll_lock` held 0, LOCK_TIMEOUT=100 → 3 PWD/RST cycles, then `fault`=1 with `pll_rst`=1. Releasing `pll_lock` has no effect until `rst`.
- Lock loss: drop `pll_lock` for 5 cycles in LOCKED → `ready` low within 3 cycles, `lock_loss_cnt`=1, RST re-entered. Asserting `cfg_req` in the same cycle defers `cfg_ack` until after relock.
- Glitch and reset: in WAIT_LOCK, lock high 10 cycles, low 1, high → stable count restarts and `ready` is delayed. Asserting `rst` mid-RECFG → all outputs are at defaults next cycle.
